// File: rtl/char_pixel_renderer.sv
// Text-mode pixel stage: decodes screen coordinates into cell/glyph addresses for the
// glyph bank and turns the returned glyph bit into a sync-aligned 3-bit RGB pixel.
module char_pixel_renderer #(
    parameter int SCALE_LOG2   = 3,
    parameter int GRID_COLS    = 4,
    parameter int GRID_ROWS    = 2,
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clock,
    input  logic       rst,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       video_active,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [2:0] fg_color,
    input  logic [2:0] bg_color,
    input  logic       cursor_en,
    input  logic [1:0] cursor_col,
    input  logic       cursor_row,
    output logic [2:0] cell_index,
    output logic [2:0] glyph_y,
    output logic [1:0] glyph_x,
    input  logic       glyph_bit,
    output logic [2:0] rgb_out,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       active_out
);

    localparam int GX_W  = 10 - SCALE_LOG2;
    localparam int COL_W = GX_W - 2;
    localparam int ROW_W = $clog2(GRID_ROWS) + 1;
    localparam int BC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef struct packed {
        logic       on_ok;
        logic [2:0] fg;
        logic [2:0] bg;
        logic       hs;
        logic       vs;
        logic       act;
    } stage_t;

    localparam stage_t STAGE_RST = '{on_ok: 1'b0, fg: 3'b000, bg: 3'b000,
                                     hs: 1'b1, vs: 1'b1, act: 1'b0};

    logic [GX_W-1:0]  gx;
    logic [GX_W-1:0]  gy;
    logic [COL_W-1:0] col;

    logic [GX_W-1:0]  trk_gy;
    logic [2:0]       trk_rem;
    logic [ROW_W-1:0] trk_row;
    logic [2:0]       cur_rem;
    logic [ROW_W-1:0] cur_row;

    logic             gap;
    logic             in_grid;
    logic             cur_hit;
    logic             vs_prev;
    logic             vs_fall;
    logic [2:0]       fg_lat;
    logic [2:0]       bg_lat;
    logic [BC_W-1:0]  blink_cnt;
    logic             blink_phase;

    logic [1:0]       s1_gx;
    stage_t           s1;
    stage_t           s2;
    stage_t           s3;
    stage_t           s1_nxt;

    logic             unused_bits;

    assign gx          = pixel_x[9:SCALE_LOG2];
    assign gy          = pixel_y[9:SCALE_LOG2];
    assign col         = gx[GX_W-1:2];
    assign unused_bits = &{1'b0, pixel_x[SCALE_LOG2-1:0]};

    // Row/remainder of gy/6 tracked incrementally: raster order means gy only ever
    // steps by one or returns to zero at the top of the frame.
    always_comb begin
        cur_rem = trk_rem;
        cur_row = trk_row;
        if (pixel_y == 10'd0) begin
            cur_rem = 3'd0;
            cur_row = '0;
        end else if (gy != trk_gy) begin
            if (trk_rem == 3'd5) begin
                cur_rem = 3'd0;
                if (trk_row != ROW_W'(GRID_ROWS))
                    cur_row = trk_row + ROW_W'(1);
            end else begin
                cur_rem = trk_rem + 3'd1;
            end
        end
    end

    assign gap     = (cur_rem == 3'd5);
    assign in_grid = video_active && (col < COL_W'(GRID_COLS)) && (cur_row < ROW_W'(GRID_ROWS));
    assign cur_hit = in_grid && cursor_en && blink_phase &&
                     (col == COL_W'(cursor_col)) && (cur_row == ROW_W'(cursor_row));
    assign vs_fall = vs_prev && !vsync_in;

    // Colours and cursor swap are resolved at decode so the pixel sees the pre-boundary state.
    always_comb begin
        s1_nxt       = STAGE_RST;
        s1_nxt.on_ok = in_grid && !gap;
        s1_nxt.fg    = cur_hit ? bg_lat : fg_lat;
        s1_nxt.bg    = cur_hit ? fg_lat : bg_lat;
        s1_nxt.hs    = hsync_in;
        s1_nxt.vs    = vsync_in;
        s1_nxt.act   = video_active;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            trk_gy      <= '0;
            trk_rem     <= 3'd0;
            trk_row     <= '0;
            vs_prev     <= 1'b1;
            fg_lat      <= 3'b111;
            bg_lat      <= 3'b000;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            trk_gy  <= gy;
            trk_rem <= cur_rem;
            trk_row <= cur_row;
            vs_prev <= vsync_in;
            if (vs_fall) begin
                fg_lat <= fg_color;
                bg_lat <= bg_color;
                if (blink_cnt == BC_W'(BLINK_FRAMES - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= !blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            cell_index <= 3'd0;
            glyph_y    <= 3'd0;
            s1_gx      <= 2'd0;
            glyph_x    <= 2'd0;
            s1         <= STAGE_RST;
            s2         <= STAGE_RST;
            s3         <= STAGE_RST;
            rgb_out    <= 3'b000;
            hsync_out  <= 1'b1;
            vsync_out  <= 1'b1;
            active_out <= 1'b0;
        end else begin
            cell_index <= in_grid ? (3'(cur_row) * 3'(GRID_COLS) + 3'(col)) : 3'd0;
            glyph_y    <= gap ? 3'd0 : cur_rem;
            s1_gx      <= gx[1:0];
            s1         <= s1_nxt;
            // glyph_x trails glyph_y by one edge to match the bank's two-stage read
            glyph_x    <= s1_gx;
            s2         <= s1;
            s3         <= s2;
            rgb_out    <= !s3.act ? 3'b000 : ((glyph_bit && s3.on_ok) ? s3.fg : s3.bg);
            hsync_out  <= s3.hs;
            vsync_out  <= s3.vs;
            active_out <= s3.act;
        end
    end

endmodule

// File: tb/tb_char_pixel_renderer.sv
// Randomized raster stimulus for char_pixel_renderer against an arithmetic reference model.
module tb_char_pixel_renderer;

    localparam int BF   = 2;
    localparam int MAXN = 16384;

    logic       clock = 1'b0;
    logic       rst;
    logic [9:0] pixel_x, pixel_y;
    logic       video_active, hsync_in, vsync_in;
    logic [2:0] fg_color, bg_color;
    logic       cursor_en;
    logic [1:0] cursor_col;
    logic       cursor_row;
    logic [2:0] cell_index, glyph_y;
    logic [1:0] glyph_x;
    logic       glyph_bit;
    logic [2:0] rgb_out;
    logic       hsync_out, vsync_out, active_out;

    always #5 clock = ~clock;

    char_pixel_renderer #(
        .SCALE_LOG2(3), .GRID_COLS(4), .GRID_ROWS(2), .BLINK_FRAMES(BF)
    ) dut (
        .clock(clock), .rst(rst),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_active(video_active),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .fg_color(fg_color), .bg_color(bg_color),
        .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .cell_index(cell_index), .glyph_y(glyph_y), .glyph_x(glyph_x),
        .glyph_bit(glyph_bit),
        .rgb_out(rgb_out), .hsync_out(hsync_out), .vsync_out(vsync_out), .active_out(active_out)
    );

    logic [5:0] exp_out [MAXN];
    logic       exp_rst [MAXN];
    logic       exp_ing [MAXN];
    logic [2:0] exp_cell[MAXN];
    logic [2:0] exp_gy  [MAXN];
    logic [1:0] exp_gx  [MAXN];
    logic       gb_q    [MAXN];

    int n     = 0;
    int n_cmp = 0;
    int n_bad = 0;
    bit force_gb = 1'b0;

    // reference state: latched colours, count of frame boundaries, previous vsync
    logic [2:0] m_fg = 3'b111;
    logic [2:0] m_bg = 3'b000;
    int         m_falls = 0;
    logic       m_vsp = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s px%0d: got %0h expected %0h", tag, n, got, exp);
        end
    endtask

    task automatic step();
        int gxv, gyv, col, row, rem;
        bit gap, ing, hit, on, ph, flush;
        logic [2:0] f, b, rgb;
        gb_q[n]    = force_gb ? 1'b1 : 1'($urandom % 2);
        exp_rst[n] = rst;
        exp_ing[n] = 1'b0;
        if (rst) begin
            m_fg = 3'b111; m_bg = 3'b000; m_falls = 0; m_vsp = 1'b1;
            exp_out[n] = 6'b000110;
        end else begin
            gxv = int'(pixel_x) >> 3;
            gyv = int'(pixel_y) >> 3;
            col = gxv / 4;
            row = gyv / 6;
            rem = gyv % 6;
            gap = (rem == 5);
            ing = video_active && col < 4 && row < 2;
            ph  = ((m_falls / BF) % 2) == 1;
            hit = ing && cursor_en && int'(cursor_col) == col && int'(cursor_row) == row && ph;
            f   = hit ? m_bg : m_fg;
            b   = hit ? m_fg : m_bg;
            on  = gb_q[n] && !gap && ing;
            rgb = !video_active ? 3'b000 : (on ? f : b);
            exp_out[n]  = {rgb, hsync_in, vsync_in, video_active};
            exp_ing[n]  = ing;
            exp_cell[n] = 3'(row * 4 + col);
            exp_gy[n]   = gap ? 3'd0 : 3'(rem);
            exp_gx[n]   = 2'(gxv % 4);
            if (m_vsp && !vsync_in) begin
                m_fg = fg_color; m_bg = bg_color; m_falls++;
            end
            m_vsp = vsync_in;
        end
        glyph_bit = (n >= 3) ? gb_q[n-3] : 1'b0;
        @(posedge clock);
        #1;
        flush = 1'b0;
        for (int k = 0; k < 4; k++)
            if (n - k >= 0 && exp_rst[n-k]) flush = 1'b1;
        if (n >= 3)
            chk("out", {26'd0, rgb_out, hsync_out, vsync_out, active_out},
                {26'd0, flush ? 6'b000110 : exp_out[n-3]});
        if (rst) begin
            chk("rst_gly", {24'd0, cell_index, glyph_y, glyph_x}, 32'd0);
        end else begin
            if (exp_ing[n]) begin
                chk("cell", {29'd0, cell_index}, {29'd0, exp_cell[n]});
                chk("gly_y", {29'd0, glyph_y}, {29'd0, exp_gy[n]});
            end
            if (n >= 1 && !exp_rst[n-1] && exp_ing[n-1])
                chk("gly_x", {30'd0, glyph_x}, {30'd0, exp_gx[n-1]});
        end
        n++;
    endtask

    task automatic pix(input int x, input int y, input bit act, input bit hs, input bit vs);
        pixel_x = 10'(x); pixel_y = 10'(y);
        video_active = act; hsync_in = hs; vsync_in = vs;
        step();
    endtask

    // One raster frame: ppl pixels per line, optional mid-line reset at rst_line.
    task automatic frame(input int ppl, input int rst_line, input bit fgb, input bit rnd);
        int vsl;
        vsl = $urandom_range(2, 98);
        force_gb = fgb;
        for (int y = 0; y < 104; y++) begin
            for (int i = 0; i < ppl; i++) begin
                if (rnd) begin
                    cursor_en  = ($urandom % 4) != 0;
                    cursor_col = 2'($urandom);
                    cursor_row = 1'($urandom);
                    if ($urandom % 64 == 0) fg_color = 3'($urandom);
                    if ($urandom % 64 == 0) bg_color = 3'($urandom);
                end
                if (y == rst_line && i == 1) begin
                    rst = 1'b1;
                    pix($urandom_range(0, 199), y, 1'b1, 1'b1, 1'b1);
                    rst = 1'b0;
                    force_gb = 1'b0;
                    return;
                end
                pix($urandom_range(0, 199), y, ($urandom % 8) != 0, i != ppl - 1,
                    !(y == vsl || y == vsl + 1));
            end
        end
        force_gb = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        pixel_x = '0; pixel_y = '0; video_active = 1'b0;
        hsync_in = 1'b1; vsync_in = 1'b1;
        fg_color = 3'b111; bg_color = 3'b000;
        cursor_en = 1'b0; cursor_col = 2'd0; cursor_row = 1'b0;
        glyph_bit = 1'b0;
        pix(0, 0, 1'b0, 1'b1, 1'b1);
        pix(0, 0, 1'b0, 1'b1, 1'b1);
        rst = 1'b0;
        // steady pixel (40,8): cell 1, glyph (1,1); hsync pulse at the 10th cycle
        for (int k = 0; k < 16; k++)
            pix(40, 8, 1'b1, k != 10, 1'b1);
        // glyph bit forced high: gap rows must show background, row 1 foreground
        frame(4, -1, 1'b1, 1'b0);
        for (int f = 0; f < 8; f++)
            frame(4, (f == 3) ? 37 : -1, 1'b0, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/char_pixel_renderer.md
# char_pixel_renderer

Pixel-pipeline stage between the VGA timing generator and the `char_memory` glyph bank. For each incoming screen coordinate it computes the character cell and glyph coordinates and drives the glyph bank's read address. It then takes back the returned glyph bit and emits a sync-aligned 3-bit RGB pixel. Fixed text grid, integer pixel scaling, per-frame colour latching and a blinking cursor.

## Interface
- `SCALE_LOG2`, 3, each glyph pixel spans 2^SCALE_LOG2 × 2^SCALE_LOG2 screen pixels
- `GRID_COLS`, 4, character cells per row (power of two, ≤ 4)
- `GRID_ROWS`, 2, character cell rows (power of two, ≤ 2)
- `BLINK_FRAMES`, 30, frames per cursor blink half-period (≥ 1)

Ports:
- `clock`  in  1  pixel clock; one clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `pixel_x`  in  10  current screen column from timing generator
- `pixel_y`  in  10  current screen row
- `video_active`  in  1  visible-area flag
- `hsync_in` / `vsync_in`  in  1  active-low syncs
- `fg_color` / `bg_color`  in  3  {R,G,B}, sampled only at frame boundary
- `cursor_en`  in  1  enable blinking cursor
- `cursor_col`  in  2  cursor cell column
- `cursor_row`  in  1  cursor cell row
- `cell_index`  out  3  `row*GRID_COLS+col`, selects `char_memory` instance
- `glyph_y`  out  3  glyph row address to `char_memory`
- `glyph_x`  out  2  glyph column address to `char_memory`
- `glyph_bit`  in  1  `data_out` of selected `char_memory`
- `rgb_out`  out  3  pixel colour
- `hsync_out` / `vsync_out` / `active_out`  out  1  syncs and active flag aligned to `rgb_out`

## Operation
- Cell geometry:
  - Each cell is 4 glyph columns × 6 glyph rows.
  - Glyph column 3 is the spacer; `char_memory` returns 0 there.
  - Glyph row 5 is the line gap; the renderer forces it blank and drives `glyph_y=0` during it.
- Coordinate decode, pure shifts with no dividers except /6:
  - `gx = pixel_x >> SCALE_LOG2` and `gy = pixel_y >> SCALE_LOG2`.
  - `col = gx >> 2`, `glyph_x = gx[1:0]`.
  - `row = gy / 6`, `glyph_y = gy % 6`. Implement via an incremental row counter reset on `pixel_y==0`, not a combinational divide.
- In-grid: `col < GRID_COLS` and `row < GRID_ROWS` and `video_active`. Out of grid gives `bg` and drives `cell_index=0`.
- Pixel value: `on = glyph_bit & ~gap_row & in_grid`, `rgb = on ? fg : bg`.
  - When the cell equals the cursor cell and `cursor_en & blink_phase`, fg and bg are swapped.
  - `rgb_out = 0` whenever `active_out=0`.
- Frame boundary is the falling edge of `vsync_in`, detected via a registered previous value. At the boundary:
  - `fg_color` and `bg_color` are latched.
  - The blink counter increments. On reaching `BLINK_FRAMES-1` it wraps to 0 and toggles `blink_phase`.
- Cursor inputs are sampled live each pixel.

## Timing
- `char_memory` read is two-stage: y is consumed one edge before x. The block therefore issues `glyph_y` one cycle ahead of `glyph_x` for the same pixel.
- Pipeline, with inputs presented before edge E1:
  - E1: decode registered; `glyph_y` and `cell_index` valid.
  - E2: `glyph_x` valid (delayed copy); memory latches row.
  - E3: `glyph_bit` valid.
  - E4: `rgb_out`, `hsync_out`, `vsync_out`, `active_out` registered.
- Fixed latency of exactly 4 cycles input→output for every signal, with no bubbles. A new pixel is accepted every cycle.
- `cell_index` is held through E3 for the glyph mux, carried in a pipeline register.
- Reset values:
  - `rgb_out=0`, `hsync_out=1`, `vsync_out=1`, `active_out=0`.
  - `glyph_x=0`, `glyph_y=0`, `cell_index=0`.
  - Blink counter 0, `blink_phase=0`, latched fg `3'b111`, latched bg `3'b000`.
- Reset asserted mid-line: all pipeline stages flush to the reset values on the next edge. The first valid output appears 4 cycles after the first sampled post-reset input.
- Simultaneous frame boundary and cursor pixel: the pixel uses the pre-toggle `blink_phase`; the new phase applies from the next cycle.
- `BLINK_FRAMES=1`: the phase toggles every frame.
- Colour inputs changing mid-frame have no visible effect until the next boundary.

## Test plan
- Reset then stream `pixel_x=40, pixel_y=8, active=1` (defaults) → after E1 `cell_index=1, glyph_y=1`; after E2 `glyph_x=1`; `rgb_out` follows `glyph_bit` 4 cycles after input.
- Latency/alignment: toggle `hsync_in` at cycle 10 → `hsync_out` toggles at cycle 14. Step 16 consecutive pixels → `rgb_out` sequence matches the model with no skips.
- Gap row: `pixel_y=40..47` (gy=5) with `glyph_bit` forced 1 → `rgb_out=bg=000`. At `pixel_y=48` (row 1, glyph_y 0) → fg `111`.
- Out of grid: `pixel_x=128` → `rgb_out=bg`, `cell_index=0`. `video_active=0` → `rgb_out=000`.
- Blink: `BLINK_FRAMES=2`, `cursor_en=1`, cursor (0,0), 4 `vsync_in` falling edges → `blink_phase` reads 0,1,1,0 across frames (toggle after 2nd). Cursor-cell pixels are inverted only while phase=1.
- Colour latch: change `fg_color` to `3'b010` mid-frame → unchanged output until the next vsync fall, then lit pixels show `010`. Assert `rst` mid-line → outputs return to reset values next edge.
